// File: rtl/mem_wb_stage_pkg.sv
// Shared widths and the write-back bus type for the MEM/WB pipeline register.
package mem_wb_stage_pkg;

  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic                 en;
    logic [REG_IDX_W-1:0] dest;
    logic [DATA_W-1:0]    value;
  } wb_bus_t;

endpackage : mem_wb_stage_pkg

// File: rtl/mem_wb_stage_perf_counter.sv
// wb_perf_counter: free-running event counter with an increment strobe.
// Synchronous active-high reset; wraps modulo 2^CNT_W.
module wb_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule : wb_perf_counter

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with freeze/flush and a forwarding tap.
// Define MEM_WB_PERF_CNT_EN to add retired/load/stall performance counters.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 flush,
  input  logic                 WB_EN_in,
  input  logic                 MEM_R_EN_in,
  input  logic                 MEM_W_EN_in,
  input  logic [DATA_W-1:0]    ALU_Res_in,
  input  logic [DATA_W-1:0]    MEM_Result_in,
  input  logic [REG_IDX_W-1:0] Dest_in,
  output logic                 WB_EN,
  output logic [REG_IDX_W-1:0] WB_Dest,
  output logic [DATA_W-1:0]    WB_Value,
  output logic                 WB_Fwd_EN,
  output logic [REG_IDX_W-1:0] WB_Fwd_Dest,
  output logic [DATA_W-1:0]    WB_Fwd_Val
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     retired_cnt,
  output logic [CNT_W-1:0]     load_cnt,
  output logic [CNT_W-1:0]     stall_cnt
`endif
);

  logic                 en_q;
  logic                 rd_q;
  logic [DATA_W-1:0]    alu_q;
  logic [DATA_W-1:0]    mem_q;
  logic [REG_IDX_W-1:0] dest_q;
  logic                 w_capture;
  wb_bus_t              w_wb;

  assign w_capture = !rst && !flush && !freeze;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      en_q   <= 1'b0;
      rd_q   <= 1'b0;
      alu_q  <= '0;
      mem_q  <= '0;
      dest_q <= '0;
    end else if (!freeze) begin
      en_q   <= WB_EN_in;
      rd_q   <= MEM_R_EN_in;
      alu_q  <= ALU_Res_in;
      mem_q  <= MEM_Result_in;
      dest_q <= Dest_in;
    end
  end

  // Write-back mux reads registers only, so no input reaches an output in the same cycle.
  assign w_wb.en    = en_q;
  assign w_wb.dest  = dest_q;
  assign w_wb.value = rd_q ? mem_q : alu_q;

  assign WB_EN       = w_wb.en;
  assign WB_Dest     = w_wb.dest;
  assign WB_Value    = w_wb.value;
  assign WB_Fwd_EN   = w_wb.en;
  assign WB_Fwd_Dest = w_wb.dest;
  assign WB_Fwd_Val  = w_wb.value;

`ifdef MEM_WB_PERF_CNT_EN
  logic w_retire;
  logic w_load;
  logic w_stall;

  // Bubbles are captured but only real register writes or stores retire.
  assign w_retire = w_capture && (WB_EN_in || MEM_W_EN_in);
  assign w_load   = w_retire && MEM_R_EN_in;
  assign w_stall  = !rst && freeze && !flush && en_q;

  wb_perf_counter #(.CNT_W(CNT_W)) u_retired_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_retire),
    .o_count (retired_cnt)
  );

  wb_perf_counter #(.CNT_W(CNT_W)) u_load_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_load),
    .o_count (load_cnt)
  );

  wb_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_stall),
    .o_count (stall_cnt)
  );
`else
  // Store indicator and counter width only matter when counters are built in.
  logic w_unused_perf;
  assign w_unused_perf = MEM_W_EN_in & w_capture & (CNT_W > 0);
`endif

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: per-cycle model compare plus directed literal checks.
module tb_mem_wb_stage;

  localparam int CNT_W = 4;
  localparam int CMOD  = 1 << CNT_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic        WB_EN_in = 1'b0;
  logic        MEM_R_EN_in = 1'b0;
  logic        MEM_W_EN_in = 1'b0;
  logic [31:0] ALU_Res_in = '0;
  logic [31:0] MEM_Result_in = '0;
  logic [3:0]  Dest_in = '0;

  logic        WB_EN, WB_Fwd_EN;
  logic [3:0]  WB_Dest, WB_Fwd_Dest;
  logic [31:0] WB_Value, WB_Fwd_Val;
`ifdef MEM_WB_PERF_CNT_EN
  logic [CNT_W-1:0] retired_cnt, load_cnt, stall_cnt;
`endif

  mem_wb_stage #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .freeze        (freeze),
    .flush         (flush),
    .WB_EN_in      (WB_EN_in),
    .MEM_R_EN_in   (MEM_R_EN_in),
    .MEM_W_EN_in   (MEM_W_EN_in),
    .ALU_Res_in    (ALU_Res_in),
    .MEM_Result_in (MEM_Result_in),
    .Dest_in       (Dest_in),
    .WB_EN         (WB_EN),
    .WB_Dest       (WB_Dest),
    .WB_Value      (WB_Value),
    .WB_Fwd_EN     (WB_Fwd_EN),
    .WB_Fwd_Dest   (WB_Fwd_Dest),
    .WB_Fwd_Val    (WB_Fwd_Val)
`ifdef MEM_WB_PERF_CNT_EN
    ,
    .retired_cnt   (retired_cnt),
    .load_cnt      (load_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: the entry visible on the write-back port and the three event tallies.
  logic        m_en;
  logic [3:0]  m_dest;
  logic [31:0] m_val;
  int          m_retired, m_load, m_stall;

  always @(posedge clk) begin
    if (rst) begin
      m_en <= 1'b0; m_dest <= '0; m_val <= '0;
      m_retired <= 0; m_load <= 0; m_stall <= 0;
    end else if (flush) begin
      m_en <= 1'b0; m_dest <= '0; m_val <= '0;
    end else if (freeze) begin
      if (m_en) m_stall <= (m_stall + 1) % CMOD;
    end else begin
      m_en   <= WB_EN_in;
      m_dest <= Dest_in;
      m_val  <= MEM_R_EN_in ? MEM_Result_in : ALU_Res_in;
      if (WB_EN_in || MEM_W_EN_in) begin
        m_retired <= (m_retired + 1) % CMOD;
        if (MEM_R_EN_in) m_load <= (m_load + 1) % CMOD;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (check_en) begin
      check("m_wb_en",    {31'b0, WB_EN},       {31'b0, m_en});
      check("m_wb_dest",  {28'b0, WB_Dest},     {28'b0, m_dest});
      check("m_wb_value", WB_Value,             m_val);
      check("m_fwd_en",   {31'b0, WB_Fwd_EN},   {31'b0, m_en});
      check("m_fwd_dest", {28'b0, WB_Fwd_Dest}, {28'b0, m_dest});
      check("m_fwd_val",  WB_Fwd_Val,           m_val);
`ifdef MEM_WB_PERF_CNT_EN
      check("m_retired",  32'(retired_cnt),     32'(m_retired));
      check("m_load",     32'(load_cnt),        32'(m_load));
      check("m_stall",    32'(stall_cnt),       32'(m_stall));
`endif
    end
  end

  // Drive one cycle of inputs at the falling edge, then settle just after the next rising edge.
  task automatic cyc(input logic wb, input logic rd, input logic wr, input logic fz,
                     input logic fl, input logic rs, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [3:0] d);
    @(negedge clk);
    WB_EN_in = wb; MEM_R_EN_in = rd; MEM_W_EN_in = wr;
    freeze = fz; flush = fl; rst = rs;
    ALU_Res_in = alu; MEM_Result_in = mem; Dest_in = d;
    @(posedge clk);
    #2;
  endtask

  task automatic lit_cnt(input string name, input int which, input int exp);
`ifdef MEM_WB_PERF_CNT_EN
    case (which)
      0:       check(name, 32'(retired_cnt), 32'(exp));
      1:       check(name, 32'(load_cnt),    32'(exp));
      default: check(name, 32'(stall_cnt),   32'(exp));
    endcase
`else
    if (name.len() < 0 || which < 0 || exp < 0) $display("unreachable");
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a live-looking entry on the inputs; it must be discarded.
    cyc(1, 1, 1, 0, 0, 1, 32'h1111, 32'h2222, 4'd9);
    check_en = 1'b1;
    cyc(1, 1, 1, 1, 0, 1, 32'h3333, 32'h4444, 4'd8);
    check("rst_wb_en", {31'b0, WB_EN}, 32'd0);
    check("rst_wb_value", WB_Value, 32'd0);
    lit_cnt("rst_retired", 0, 0);

    // Load.
    cyc(1, 1, 0, 0, 0, 0, 32'h100, 32'hDEADBEEF, 4'd5);
    check("load_en", {31'b0, WB_EN}, 32'd1);
    check("load_dest", {28'b0, WB_Dest}, 32'd5);
    check("load_value", WB_Value, 32'hDEADBEEF);
    lit_cnt("load_cnt", 1, 1);

    // ALU op.
    cyc(1, 0, 0, 0, 0, 0, 32'h2A, 32'h5555, 4'd3);
    check("alu_value", WB_Value, 32'h2A);
    lit_cnt("alu_retired", 0, 2);
    lit_cnt("alu_load", 1, 1);

    // Freeze for 3 cycles while inputs change.
    for (int i = 0; i < 3; i++) begin
      cyc(1, i[0], 0, 1, 0, 0, 32'h70 + i, 32'hF0 + i, 4'(i + 10));
      check("frz_value", WB_Value, 32'h2A);
      check("frz_dest", {28'b0, WB_Dest}, 32'd3);
    end
    lit_cnt("frz_stall", 2, 3);
    cyc(1, 0, 0, 0, 0, 0, 32'h99, 32'h0, 4'd9);
    check("unfrz_value", WB_Value, 32'h99);
    check("unfrz_dest", {28'b0, WB_Dest}, 32'd9);

    // Flush together with freeze on a valid entry.
    cyc(1, 1, 0, 1, 1, 0, 32'hAA, 32'hBB, 4'd7);
    check("flush_en", {31'b0, WB_EN}, 32'd0);
    check("flush_value", WB_Value, 32'd0);
    lit_cnt("flush_stall", 2, 3);

    // Freeze over a bubble does not count as a stall.
    cyc(1, 0, 0, 1, 0, 0, 32'h5, 32'h6, 4'd1);
    lit_cnt("bubble_frz_stall", 2, 3);

    // Store-only retires without a register write; pure bubble does not retire.
    cyc(0, 0, 1, 0, 0, 0, 32'h40, 32'h0, 4'd2);
    check("store_en", {31'b0, WB_EN}, 32'd0);
    lit_cnt("store_retired", 0, 4);
    cyc(0, 0, 0, 0, 0, 0, 32'h41, 32'h0, 4'd2);
    lit_cnt("bubble_retired", 0, 4);

    // 12 more retire events take the 4-bit counter from 4 through 16 back to 0.
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0, 0, 32'h200 + i, 32'h0, 4'(i));
    lit_cnt("wrap_retired", 0, 0);
    check("wrap_value", WB_Value, 32'h20B);

    // Mid-stream reset while frozen on a valid entry.
    cyc(1, 0, 0, 0, 0, 0, 32'hAB, 32'h0, 4'd4);
    cyc(1, 1, 1, 1, 0, 1, 32'hEE, 32'hFF, 4'd6);
    check("mrst_en", {31'b0, WB_EN}, 32'd0);
    check("mrst_value", WB_Value, 32'd0);
    check("mrst_dest", {28'b0, WB_Dest}, 32'd0);
    lit_cnt("mrst_retired", 0, 0);
    lit_cnt("mrst_stall", 2, 0);
    cyc(1, 0, 0, 0, 0, 0, 32'hCD, 32'h0, 4'd2);
    check("post_rst_value", WB_Value, 32'hCD);
    check("post_rst_en", {31'b0, WB_EN}, 32'd1);
    lit_cnt("post_rst_retired", 0, 1);

    @(negedge clk);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_wb_stage
